// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: FSM encoding, wait-counter width
// and the even-parity helper used when DMEM_PARITY_EN is defined.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACC_LO = 3'd2,
        ST_ACC_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int WCNT_W = 4;

    // Even-parity bit over a word; callers zero-extend to 64 bits.
    function automatic logic parity_even(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, write-first, registered read data. Contents are not reset.
module dmem_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
            rdata_q     <= i_wdata;
        end else begin
            rdata_q     <= mem[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request port, wait states, single/double-word access,
// range check. Optional per-word parity when DMEM_PARITY_EN is defined.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_write,
    input  logic                i_req_double,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [2*DATA_W-1:0] i_req_wdata,
    output logic                o_rsp_valid,
    output logic [2*DATA_W-1:0] o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_par_err
);

    localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] ZW      = '0;

    state_e                state_q, state_d;
    logic                  write_q, write_d, double_q, double_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [2*DATA_W-1:0]   wdata_q, wdata_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic                  lo_perr_q, lo_perr_d;
    logic                  ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d, par_err_q, par_err_d;

    logic [ADDR_W-1:0]     addr_hi, cur_addr;
    logic                  lo_oor, hi_oor, cur_oor, in_acc, ram_we, rd_perr;
    logic [DATA_W-1:0]     wr_half, rd_word;
    logic [MW-1:0]         ram_wdata, ram_rdata;

    // Second word wraps naturally at 2**ADDR_W.
    assign addr_hi  = addr_q + ADDR_W'(1);
    assign lo_oor   = {1'b0, addr_q}  >= DEPTH_L;
    assign hi_oor   = {1'b0, addr_hi} >= DEPTH_L;
    assign in_acc   = (state_q == ST_ACC_LO) || (state_q == ST_ACC_HI);
    assign cur_addr = (state_q == ST_ACC_HI) ? addr_hi : addr_q;
    assign cur_oor  = (state_q == ST_ACC_HI) ? hi_oor : lo_oor;
    assign wr_half  = (state_q == ST_ACC_HI) ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
    assign ram_we   = in_acc && write_q && !cur_oor;
    assign rd_word  = ram_rdata[DATA_W-1:0];

`ifdef DMEM_PARITY_EN
    assign ram_wdata = {parity_even(64'(wr_half)), wr_half};
    assign rd_perr   = parity_even(64'(rd_word)) != ram_rdata[DATA_W];
`else
    assign ram_wdata = wr_half;
    assign rd_perr   = 1'b0;
`endif

    dmem_array #(.WIDTH(MW), .DEPTH(DEPTH), .AW(AIW)) u_arr (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_addr  (cur_addr[AIW-1:0]),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        double_d    = double_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wcnt_d      = wcnt_q;
        lo_d        = lo_q;
        lo_perr_d   = lo_perr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        par_err_d   = par_err_q;
        case (state_q)
            ST_IDLE: if (i_req_valid && ready_q) begin
                write_d  = i_req_write;
                double_d = i_req_double;
                addr_d   = i_req_addr;
                wdata_d  = i_req_wdata;
                if (WAIT_CYCLES > 0) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
                end else begin
                    state_d = ST_ACC_LO;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == '0) state_d = ST_ACC_LO;
                else              wcnt_d  = wcnt_q - WCNT_W'(1);
            end
            ST_ACC_LO: state_d = double_q ? ST_ACC_HI : ST_DONE;
            // Low-word read data is on the RAM output now; park it while the high word is read.
            ST_ACC_HI: begin
                state_d   = ST_DONE;
                lo_d      = lo_oor ? ZW : rd_word;
                lo_perr_d = !lo_oor && rd_perr;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = lo_oor || (double_q && hi_oor);
                par_err_d   = 1'b0;
                // Single reads return zero in the upper half.
                if (!write_q) begin
                    if (double_q) begin
                        rsp_rdata_d = {hi_oor ? ZW : rd_word, lo_q};
                        par_err_d   = lo_perr_q || (!hi_oor && rd_perr);
                    end else begin
                        rsp_rdata_d = {ZW, lo_oor ? ZW : rd_word};
                        par_err_d   = !lo_oor && rd_perr;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            double_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wcnt_q      <= '0;
            lo_q        <= '0;
            lo_perr_q   <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            double_q    <= double_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            lo_q        <= lo_d;
            lo_perr_q   <= lo_perr_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            par_err_q   <= par_err_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_par_err   = par_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a zero-wait instance driven from a vector table, and a
// three-wait-state instance for held-request and latency sequences.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst0_n, rst3_n;
    logic        v0, w0, db0, rdy0, rv0, re0, pe0;
    logic [15:0] a0;
    logic [31:0] wd0, rd0;
    logic        v3, w3, db3, rdy3, rv3, re3, pe3;
    logic [15:0] a3;
    logic [31:0] wd3, rd3;

    int checks = 0;
    int errors = 0;
    int acc3   = 0;
    int pulse3 = 0;
    int pulse0 = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_CYCLES(0)) u_d0 (
        .i_clk(clk), .i_rst_n(rst0_n), .i_req_valid(v0), .o_req_ready(rdy0),
        .i_req_write(w0), .i_req_double(db0), .i_req_addr(a0), .i_req_wdata(wd0),
        .o_rsp_valid(rv0), .o_rsp_rdata(rd0), .o_rsp_err(re0), .o_par_err(pe0));

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_CYCLES(3)) u_d3 (
        .i_clk(clk), .i_rst_n(rst3_n), .i_req_valid(v3), .o_req_ready(rdy3),
        .i_req_write(w3), .i_req_double(db3), .i_req_addr(a3), .i_req_wdata(wd3),
        .o_rsp_valid(rv3), .o_rsp_rdata(rd3), .o_rsp_err(re3), .o_par_err(pe3));

    always @(posedge clk) begin
        if (v3 && rdy3) acc3 <= acc3 + 1;
        if (rv3)        pulse3 <= pulse3 + 1;
        if (rv0)        pulse0 <= pulse0 + 1;
    end

    typedef struct {
        logic        wr;
        logic        dbl;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t tv [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request on the zero-wait instance; lat = rising edges from accept to rsp_valid.
    task automatic req0(input logic wr, input logic dbl, input logic [15:0] addr,
                        input logic [31:0] wdata, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy0 && n < 20) begin @(negedge clk); n++; end
        lat = -2;
        if (rdy0) begin
            v0 = 1'b1; w0 = wr; db0 = dbl; a0 = addr; wd0 = wdata;
            @(posedge clk); #1;
            v0 = 1'b0;
            lat = -1;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (rv0) begin lat = k; break; end
            end
        end
    endtask

    // Held request on the three-wait instance; counts busy cycles and latency.
    task automatic run_d3(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          output int lowcnt, output int lat);
        lowcnt = 0;
        lat    = -1;
        @(negedge clk);
        v3 = 1'b1; w3 = wr; db3 = 1'b0; a3 = addr; wd3 = wdata;
        @(posedge clk); #1;
        if (!rdy3) lowcnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (rv3) begin lat = k; break; end
            if (!rdy3) lowcnt++;
        end
        @(negedge clk);
        v3 = 1'b0;
    endtask

    initial begin
        int lat, lowcnt, p;
        tv[0]  = '{1'b1, 1'b0, 16'h0000, 32'h0000_5555, 32'h0000_0000, 1'b0, 2};
        tv[1]  = '{1'b1, 1'b0, 16'h0010, 32'h0000_0A00, 32'h0000_0000, 1'b0, 2};
        tv[2]  = '{1'b0, 1'b0, 16'h0010, 32'h0,         32'h0000_0A00, 1'b0, 2};
        tv[3]  = '{1'b1, 1'b1, 16'h0100, 32'hDEAD_BEEF, 32'h0000_0A00, 1'b0, 3};
        tv[4]  = '{1'b0, 1'b0, 16'h0100, 32'h0,         32'h0000_BEEF, 1'b0, 2};
        tv[5]  = '{1'b0, 1'b0, 16'h0101, 32'h0,         32'h0000_DEAD, 1'b0, 2};
        tv[6]  = '{1'b0, 1'b1, 16'h0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        tv[7]  = '{1'b1, 1'b0, 16'h1000, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 2};
        tv[8]  = '{1'b0, 1'b0, 16'h0000, 32'h0,         32'h0000_5555, 1'b0, 2};
        tv[9]  = '{1'b1, 1'b0, 16'h0FFF, 32'h0000_7777, 32'h0000_5555, 1'b0, 2};
        tv[10] = '{1'b0, 1'b1, 16'h0FFF, 32'h0,         32'h0000_7777, 1'b1, 3};
        tv[11] = '{1'b1, 1'b1, 16'hFFFF, 32'hAAAA_BBBB, 32'h0000_7777, 1'b1, 3};
        tv[12] = '{1'b0, 1'b0, 16'h0000, 32'h0,         32'h0000_AAAA, 1'b0, 2};
        tv[13] = '{1'b0, 1'b0, 16'h1000, 32'h0,         32'h0000_0000, 1'b1, 2};

        rst0_n = 1'b0; rst3_n = 1'b0;
        v0 = 1'b0; w0 = 1'b0; db0 = 1'b0; a0 = '0; wd0 = '0;
        v3 = 1'b0; w3 = 1'b0; db3 = 1'b0; a3 = '0; wd3 = '0;
        repeat (3) @(negedge clk);
        check("rst0 ready", 32'(rdy0), 32'd1);
        check("rst0 valid", 32'(rv0),  32'd0);
        check("rst0 rdata", rd0,       32'd0);
        check("rst0 err",   32'(re0),  32'd0);
        check("rst0 par",   32'(pe0),  32'd0);
        check("rst3 ready", 32'(rdy3), 32'd1);
        check("rst3 valid", 32'(rv3),  32'd0);
        check("rst3 rdata", rd3,       32'd0);
        rst0_n = 1'b1; rst3_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req0(tv[i].wr, tv[i].dbl, tv[i].addr, tv[i].wdata, lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].lat));
            check($sformatf("v%0d rdata", i),   rd0,      tv[i].rdata);
            check($sformatf("v%0d err", i),     32'(re0), 32'(tv[i].err));
            check($sformatf("v%0d par", i),     32'(pe0), 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d pulse", i),   32'(rv0), 32'd0);
        end

        // Held request with three wait states, then a read-back of the same word.
        run_d3(1'b1, 16'h0005, 32'h0000_00C3, lowcnt, lat);
        check("w3 busy cycles", 32'(lowcnt), 32'd5);
        check("w3 latency",     32'(lat),    32'd5);
        repeat (8) @(posedge clk);
        #1;
        check("w3 accepts",     32'(acc3),   32'd1);
        check("w3 pulses",      32'(pulse3), 32'd1);
        run_d3(1'b0, 16'h0005, 32'h0, lowcnt, lat);
        check("r3 latency",     32'(lat),    32'd5);
        check("r3 rdata",       rd3,         32'h0000_00C3);
        check("r3 err",         32'(re3),    32'd0);

        // Reset while the high word of a double write is in flight.
        req0(1'b1, 1'b0, 16'h0201, 32'h0000_0BAD, lat);
        req0(1'b1, 1'b0, 16'h0200, 32'h0000_1111, lat);
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b1; db0 = 1'b1; a0 = 16'h0200; wd0 = 32'h4444_3333;
        @(posedge clk); #1;
        v0 = 1'b0;
        @(posedge clk); #1;
        p = pulse0;
        rst0_n = 1'b0;
        #1;
        check("midrst ready", 32'(rdy0), 32'd1);
        check("midrst valid", 32'(rv0),  32'd0);
        check("midrst rdata", rd0,       32'd0);
        @(posedge clk);
        @(negedge clk);
        rst0_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst no pulse", 32'(pulse0), 32'(p));
        req0(1'b0, 1'b0, 16'h0200, 32'h0, lat);
        check("midrst lo word", rd0, 32'h0000_3333);
        req0(1'b0, 1'b0, 16'h0201, 32'h0, lat);
        check("midrst hi word", rd0, 32'h0000_0BAD);

`ifdef DMEM_PARITY_EN
        req0(1'b1, 1'b0, 16'h0020, 32'h0000_00F0, lat);
        u_d0.u_arr.mem[32] = u_d0.u_arr.mem[32] ^ 17'h00001;
        req0(1'b0, 1'b0, 16'h0020, 32'h0, lat);
        check("parity flag",  32'(pe0), 32'd1);
        check("parity rdata", rd0,       32'h0000_00F1);
`else
        req0(1'b1, 1'b0, 16'h0020, 32'h0000_00F0, lat);
        req0(1'b0, 1'b0, 16'h0020, 32'h0, lat);
        check("noparity flag",  32'(pe0), 32'd0);
        check("noparity rdata", rd0,      32'h0000_00F0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
